// File: rtl/modbus_rtu_tx_framer_if.sv
// Byte-stream handshake bundle for the Modbus RTU TX framer:
// payload in from the message buffer, framed bytes out to the UART.
interface modbus_rtu_tx_framer_if;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // framer side
  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  // producer / UART side
  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/modbus_rtu_tx_framer.sv
// Modbus RTU transmit framer: forwards payload bytes, computes CRC-16/Modbus
// bit-serially (8 clk per byte), appends CRC lo/hi and holds the 3.5-char
// inter-frame silence before the next frame may start.
module modbus_rtu_tx_framer #(
  parameter int GAP_CLKS = 16710,
  parameter int MAX_LEN  = 254
) (
  input  logic                  clk,
  input  logic                  reset,
  modbus_rtu_tx_framer_if.slave bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  len_err,
  output logic [15:0]           crc_out
);

  typedef enum logic [2:0] {
    S_LOAD, S_CALC, S_SEND_DATA, S_SEND_CRC_LO, S_SEND_CRC_HI, S_GAP
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_crc;
  logic [7:0]  r_cnt;
  logic [3:0]  r_bit;
  logic [7:0]  r_byte;
  logic        r_last;
  logic        r_busy;
  logic        r_frame_done;
  logic        r_len_err;
  logic [15:0] r_crc_out;
  logic [15:0] r_gap;

  logic        w_accept;
  logic [7:0]  w_cnt_inc;
  logic        w_force;
  logic        w_bit_done;
  logic        w_gap_zero;
  logic [15:0] w_crc_shift;

  assign w_accept    = bus.in_valid && (r_state == S_LOAD);
  assign w_cnt_inc   = r_cnt + 8'd1;
  assign w_force     = (w_cnt_inc == 8'(MAX_LEN));
  // r_bit counts shifts done; the extra cycle at 8 is the hand-off to SEND_DATA
  assign w_bit_done  = (r_bit == 4'd8);
  assign w_gap_zero  = (r_gap == 16'd0);
  assign w_crc_shift = r_crc[0] ? ((r_crc >> 1) ^ 16'hA001) : (r_crc >> 1);

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign len_err    = r_len_err;
  assign crc_out    = r_crc_out;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    case (r_state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next = S_CALC;
      end
      S_CALC: begin
        if (w_bit_done) w_next = S_SEND_DATA;
      end
      S_SEND_DATA: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_byte;
        if (bus.out_ready) w_next = r_last ? S_SEND_CRC_LO : S_LOAD;
      end
      S_SEND_CRC_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_crc[7:0];
        if (bus.out_ready) w_next = S_SEND_CRC_HI;
      end
      S_SEND_CRC_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = r_crc[15:8];
        if (bus.out_ready) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_gap_zero) w_next = S_LOAD;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // Datapath: byte latch, CRC engine, counters and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crc        <= 16'hFFFF;
      r_cnt        <= 8'd0;
      r_bit        <= 4'd0;
      r_byte       <= 8'h00;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      r_crc_out    <= 16'h0000;
      r_gap        <= 16'd0;
    end else begin
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_byte     <= bus.in_data;
            r_crc      <= {r_crc[15:8], r_crc[7:0] ^ bus.in_data};
            r_cnt      <= w_cnt_inc;
            r_busy     <= 1'b1;
            r_bit      <= 4'd0;
            r_last     <= bus.in_last | w_force;
            r_len_err  <= w_force & ~bus.in_last;
          end
        end
        S_CALC: begin
          if (!w_bit_done) begin
            r_crc <= w_crc_shift;
            r_bit <= r_bit + 4'd1;
          end
        end
        S_SEND_CRC_HI: begin
          if (bus.out_ready) begin
            r_crc_out <= r_crc;
            r_gap     <= 16'(GAP_CLKS - 1);
          end
        end
        S_GAP: begin
          if (w_gap_zero) begin
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_crc        <= 16'hFFFF;
            r_cnt        <= 8'd0;
          end else begin
            r_gap <= r_gap - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_tx_framer.sv
// Self-checking bench for modbus_rtu_tx_framer: table of frames plus
// hand-written corner sequences; output bytes checked through a scoreboard.
module tb_modbus_rtu_tx_framer;

  localparam int GAP = 20;

  logic clk, reset;
  logic busy_a, fd_a, le_a, busy_b, fd_b, le_b;
  logic [15:0] co_a, co_b;

  modbus_rtu_tx_framer_if ifa();
  modbus_rtu_tx_framer_if ifb();

  modbus_rtu_tx_framer #(.GAP_CLKS(GAP), .MAX_LEN(254)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa),
    .busy(busy_a), .frame_done(fd_a), .len_err(le_a), .crc_out(co_a));

  modbus_rtu_tx_framer #(.GAP_CLKS(GAP), .MAX_LEN(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb),
    .busy(busy_b), .frame_done(fd_b), .len_err(le_b), .crc_out(co_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct { logic [7:0] d; bit hi; } exp_t;
  exp_t q0[$], q1[$];

  typedef struct {
    logic [7:0]  d[8];
    int          len;
    logic [15:0] crc;
    bit          rnd;
  } vec_t;
  vec_t vt[3];

  bit          rdy_rand = 0;
  int          gap_start[2], gap_viol[2], done_cnt[2], lerr_cnt[2];
  bit          in_gap[2], pv[2], pr[2];
  logic [7:0]  pd[2];

  function automatic void chk_eq(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] crc16(input logic [7:0] b[8], input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic void push(int k, logic [7:0] d, bit hi);
    exp_t e;
    e.d = d; e.hi = hi;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic void push_frame(int k, logic [7:0] d[8], int n, logic [15:0] c);
    for (int i = 0; i < n; i++) push(k, d[i], 1'b0);
    push(k, c[7:0], 1'b0);
    push(k, c[15:8], 1'b1);
  endfunction

  // Per-negedge monitor: scoreboard pops, stall stability, gap timing/quietness
  function automatic void mon(int k, logic ov, logic orr, logic [7:0] od,
                              logic ir, logic fd, logic bz, logic le);
    exp_t e;
    int   sz;
    if (le) lerr_cnt[k]++;
    if (pv[k] && !pr[k]) begin
      chk_eq($sformatf("stall_valid%0d", k), int'(ov), 1);
      chk_eq($sformatf("stall_data%0d", k), int'(od), int'(pd[k]));
    end
    if (fd) begin
      chk_eq($sformatf("fd_expected%0d", k), int'(in_gap[k]), 1);
      chk_eq($sformatf("gap_len%0d", k), cyc - gap_start[k], GAP);
      chk_eq($sformatf("busy_fall%0d", k), int'(bz), 0);
      chk_eq($sformatf("gap_quiet%0d", k), gap_viol[k], 0);
      in_gap[k] = 0;
      done_cnt[k]++;
    end else if (in_gap[k]) begin
      if (ir !== 1'b0 || ov !== 1'b0) gap_viol[k]++;
    end
    if (ov && orr) begin
      sz = (k == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk_eq($sformatf("unexpected_byte%0d", k), int'(od), -1);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk_eq($sformatf("out_byte%0d", k), int'(od), int'(e.d));
        if (e.hi) begin
          in_gap[k] = 1; gap_start[k] = cyc + 1; gap_viol[k] = 0;
        end
      end
    end
    pv[k] = ov; pr[k] = orr; pd[k] = od;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      mon(0, ifa.out_valid, ifa.out_ready, ifa.out_data, ifa.in_ready, fd_a, busy_a, le_a);
      mon(1, ifb.out_valid, ifb.out_ready, ifb.out_data, ifb.in_ready, fd_b, busy_b, le_b);
    end
  end

  // UART-side ready: tied high or random, changed just after each edge
  initial begin
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifa.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_byte(input int k, input logic [7:0] d, input logic l, output int acc);
    int   n = 0;
    logic rdy = 1'b0;
    acc = -1;
    if (k == 0) begin ifa.in_data = d; ifa.in_last = l; ifa.in_valid = 1'b1; end
    else        begin ifb.in_data = d; ifb.in_last = l; ifb.in_valid = 1'b1; end
    while (!rdy && n < 400) begin
      @(negedge clk);
      rdy = (k == 0) ? ifa.in_ready : ifb.in_ready;
      n++;
    end
    if (!rdy) chk_eq("accept_timeout", n, 0);
    else acc = cyc + 1;
    @(posedge clk); #1;
    if (k == 0) begin ifa.in_valid = 1'b0; ifa.in_last = 1'b0; end
    else        begin ifb.in_valid = 1'b0; ifb.in_last = 1'b0; end
  endtask

  task automatic wait_done(input int k, input int target);
    int n = 0;
    while (done_cnt[k] < target && n < 3000) begin
      @(negedge clk); n++;
    end
    chk_eq($sformatf("frame_done_wait%0d", k), int'(done_cnt[k] >= target), 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_eq({tag, "_in_ready"},  int'(ifa.in_ready), 1);
    chk_eq({tag, "_out_valid"}, int'(ifa.out_valid), 0);
    chk_eq({tag, "_out_data"},  int'(ifa.out_data), 0);
    chk_eq({tag, "_busy"},      int'(busy_a), 0);
    chk_eq({tag, "_frame_done"},int'(fd_a), 0);
    chk_eq({tag, "_len_err"},   int'(le_a), 0);
    chk_eq({tag, "_crc_out"},   int'(co_a), 0);
  endtask

  logic [7:0] fx[8], fy[8];
  int acc, exp_done_a, lat;

  initial begin
    reset = 1'b1;
    ifa.in_data = 0; ifa.in_last = 0; ifa.in_valid = 0;
    ifb.in_data = 0; ifb.in_last = 0; ifb.in_valid = 0;
    exp_done_a = 0;

    vt[0].d = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    vt[0].len = 6; vt[0].crc = 16'h0A84; vt[0].rnd = 0;
    vt[1].d = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00};
    vt[1].len = 6; vt[1].crc = 16'hCDC5; vt[1].rnd = 1;
    vt[2].d = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[2].len = 1; vt[2].crc = 16'h807E; vt[2].rnd = 1;

    repeat (3) @(negedge clk);
    chk_reset_vals("init");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // table-driven frames
    for (int i = 0; i < 3; i++) begin
      rdy_rand = vt[i].rnd;
      push_frame(0, vt[i].d, vt[i].len, vt[i].crc);
      for (int j = 0; j < vt[i].len; j++) begin
        send_byte(0, vt[i].d[j], j == vt[i].len - 1, acc);
        if (j == 0) begin
          @(negedge clk);
          chk_eq("busy_rise", int'(busy_a), 1);
          @(posedge clk); #1;
        end
      end
      exp_done_a++;
      wait_done(0, exp_done_a);
      chk_eq($sformatf("crc_out_vec%0d", i), int'(co_a), int'(vt[i].crc));
      rdy_rand = 0;
    end

    // back-to-back frames with in_valid held through the gap
    fx = '{8'h05, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    fy = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(0, fx, 3, crc16(fx, 3));
    push_frame(0, fy, 4, crc16(fy, 4));
    for (int j = 0; j < 3; j++) send_byte(0, fx[j], j == 2, acc);
    for (int j = 0; j < 4; j++) send_byte(0, fy[j], j == 3, acc);
    exp_done_a += 2;
    wait_done(0, exp_done_a);
    chk_eq("crc_out_b2b", int'(co_a), int'(crc16(fy, 4)));

    // single-byte frame with accept-to-out_valid latency
    fx = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(0, fx, 1, crc16(fx, 1));
    send_byte(0, 8'h01, 1'b1, acc);
    lat = -1;
    for (int n = 0; n < 30 && lat < 0; n++) begin
      @(negedge clk);
      if (ifa.out_valid) lat = cyc - acc;
    end
    chk_eq("latency", lat, 9);
    @(posedge clk); #1;
    exp_done_a++;
    wait_done(0, exp_done_a);
    chk_eq("crc_out_single", int'(co_a), int'(crc16(fx, 1)));

    // reset during CALC of the 3rd byte, then a clean frame
    push(0, 8'h01, 1'b0);
    push(0, 8'h03, 1'b0);
    send_byte(0, 8'h01, 1'b0, acc);
    send_byte(0, 8'h03, 1'b0, acc);
    send_byte(0, 8'h00, 1'b0, acc);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    chk_eq("abort_queue", q0.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    push_frame(0, vt[0].d, 6, vt[0].crc);
    for (int j = 0; j < 6; j++) send_byte(0, vt[0].d[j], j == 5, acc);
    exp_done_a++;
    wait_done(0, exp_done_a);
    chk_eq("crc_out_after_rst", int'(co_a), int'(vt[0].crc));

    // MAX_LEN=4 forced termination on the second instance
    fx = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    fy = '{8'h50, 8'h60, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_frame(1, fx, 4, crc16(fx, 4));
    push_frame(1, fy, 3, crc16(fy, 3));
    for (int j = 0; j < 4; j++) begin
      send_byte(1, fx[j], 1'b0, acc);
      if (j == 3) begin
        @(negedge clk);
        chk_eq("len_err_pulse", int'(le_b), 1);
        @(negedge clk);
        chk_eq("len_err_clear", int'(le_b), 0);
        @(posedge clk); #1;
      end
    end
    wait_done(1, 1);
    chk_eq("crc_out_maxlen", int'(co_b), int'(crc16(fx, 4)));
    send_byte(1, fy[0], 1'b0, acc);
    send_byte(1, fy[1], 1'b0, acc);
    send_byte(1, fy[2], 1'b1, acc);
    wait_done(1, 2);
    chk_eq("crc_out_maxlen2", int'(co_b), int'(crc16(fy, 3)));
    chk_eq("len_err_count_b", lerr_cnt[1], 1);
    chk_eq("len_err_count_a", lerr_cnt[0], 0);

    repeat (3) @(posedge clk);
    chk_eq("queue_a_empty", q0.size(), 0);
    chk_eq("queue_b_empty", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modbus_rtu_tx_framer.md
Name: modbus_rtu_tx_framer

Overview:
Transmit-side Modbus RTU framer, the TX counterpart of the RX CRC checker. Accepts payload bytes (address, function, data) from the TX message buffer. Computes the CRC-16/Modbus bit-serially, 8 cycles per byte (polynomial 0xA001 reflected, init 0xFFFF). Presents each payload byte, then the CRC low byte, then the CRC high byte, to the UART transmitter over a valid/ready handshake, and enforces the 3.5-character inter-frame silence before the next frame may start.

Parameters:
GAP_CLKS, 16710, inter-frame silence in clk cycles, counted from the CRC-high handshake (3.5 chars of 11 bits at 115200 baud from 50 MHz); legal range 1..65535.
MAX_LEN, 254, maximum payload bytes per frame (excluding the 2 CRC bytes); legal range 1..254.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_data  in  8  payload byte
in_last  in  1  marks in_data as the final payload byte of the frame
in_valid  in  1  in_data/in_last valid
in_ready  out  1  framer accepts a byte this cycle
out_data  out  8  byte to UART transmitter
out_valid  out  1  out_data valid; held with out_data stable until out_ready
out_ready  in  1  UART transmitter takes out_data
busy  out  1  high from the first accepted byte of a frame until the gap ends
frame_done  out  1  one-cycle pulse on the cycle the gap ends
len_err  out  1  one-cycle pulse when a byte is force-terminated as last because MAX_LEN was reached
crc_out  out  16  CRC of the most recent completed frame, {hi, lo}

Behaviour:
- Reset values (asynchronous): state=LOAD, crc=16'hFFFF, byte count=0, in_ready=1, out_valid=0, out_data=0, busy=0, frame_done=0, len_err=0, crc_out=0.
- States: LOAD, CALC, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, GAP.
- LOAD:
  - in_ready=1 only in LOAD.
  - On in_valid&in_ready: latch the byte; set crc[7:0] ^= in_data; increment the byte count; set busy=1; set bit counter=0; go to CALC.
  - The latched last flag is (in_last OR count==MAX_LEN). If the byte is forced last without in_last, pulse len_err on the cycle after acceptance.
- CALC, 8 cycles, one bit per cycle:
  - If crc[0]=1: crc <= (crc>>1)^16'hA001.
  - Else: crc <= crc>>1.
  - After the 8th shift, go to SEND_DATA.
- SEND_DATA:
  - out_valid=1, out_data=latched byte.
  - On out_ready: if last, go to SEND_CRC_LO; else go to LOAD.
  - Latency: byte accepted at edge T gives out_valid high from edge T+9.
- SEND_CRC_LO: out_data=crc[7:0]; on out_ready go to SEND_CRC_HI.
- SEND_CRC_HI:
  - out_data=crc[15:8].
  - On out_ready: crc_out<=crc; load the gap counter with GAP_CLKS-1; go to GAP.
- GAP:
  - Counts down to 0 with in_ready=0 and out_valid=0.
  - At 0: pulse frame_done, set busy=0, crc=16'hFFFF, count=0, go to LOAD.
  - A byte presented during GAP waits (in_valid held) and is accepted on the first LOAD cycle.
- Handshake rules:
  - out_valid never drops without out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_ready stalls of any length are allowed in every SEND state.
  - out_ready high outside the SEND states is ignored.
- A 1-byte frame is legal: sent as payload byte, CRC lo, CRC hi.
- crc is not reset between bytes of the same frame; it is reset only by GAP completion or reset.
- reset mid-frame (any state): return immediately to reset values. The partial frame is abandoned with no CRC emitted and no frame_done. The next accepted byte starts a fresh frame with crc=FFFF.
- in_valid with in_ready=0 has no effect. The byte is not consumed.

Test Plan:
- GAP_CLKS=20. Send 01 03 00 00 00 01 (last on 6th), out_ready tied 1 -> out bytes 01 03 00 00 00 01 84 0A; crc_out=16'h0A84; frame_done pulses exactly 20 cycles after the 0A handshake; busy falls with frame_done.
- Send 01 03 00 00 00 0A, with out_ready toggling randomly -> out sequence 01 03 00 00 00 0A C5 CD; out_data stable during every stall.
- Back-to-back frames, in_valid held high through GAP -> in_ready=0 throughout GAP; the second frame's CRC starts at FFFF and matches the reference model; no byte lost.
- MAX_LEN=4, stream 6 bytes without in_last -> len_err pulse on the 4th byte; CRC of the first 4 bytes is appended; bytes 5-6 begin a new frame after the gap.
- Assert reset during CALC of the 3rd byte, then send 01 03 00 00 00 01 -> no CRC emitted for the aborted frame; new frame ends in 84 0A; all outputs at reset values while reset is high.
- Single-byte frame 0x01 with in_last -> out 01 followed by the reference-model CRC lo/hi; 9-cycle accept-to-out_valid latency checked.
